// File: rtl/rf_write_arbiter.sv
// Write-side front end for the multi-port register file: per-lane FIFOs,
// same-address collision resolution by lane priority, registered RF write ports.
module rf_write_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned LANES         = 4,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                                      clk_i,
  input  logic                                      arst_i,
  input  logic [LANES-1:0]                          req_valid_i,
  input  logic [LANES-1:0][ADDRESS_WIDTH-1:0]       req_addr_i,
  input  logic [LANES-1:0][WORD_WIDTH-1:0]          req_data_i,
  output logic [LANES-1:0]                          req_ready_o,
  output logic [LANES-1:0][ADDRESS_WIDTH-1:0]       select_r_o,
  output logic [LANES-1:0][WORD_WIDTH-1:0]          data_o,
  output logic [LANES-1:0]                          enable_writing_o,
  output logic                                      busy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDRESS_WIDTH-1:0] mem_addr [LANES][DEPTH];
  logic [WORD_WIDTH-1:0]    mem_data [LANES][DEPTH];

  logic [LANES-1:0][PTR_W-1:0]         wr_ptr;
  logic [LANES-1:0][PTR_W-1:0]         rd_ptr;
  logic [LANES-1:0][CNT_W-1:0]         count;
  logic [LANES-1:0][ADDRESS_WIDTH-1:0] head_addr;
  logic [LANES-1:0][WORD_WIDTH-1:0]    head_data;
  logic [LANES-1:0]                    nonempty;
  logic [LANES-1:0]                    push;
  logic [LANES-1:0]                    grant;

  // Ready depends only on registered count; held low while in reset.
  always_comb begin
    req_ready_o = '0;
    push        = '0;
    for (int i = 0; i < LANES; i++) begin
      req_ready_o[i] = arst_i && (count[i] != CNT_W'(DEPTH));
      push[i]        = req_valid_i[i] && req_ready_o[i];
    end
  end

  // Lowest lane wins a same-address collision; all other candidates go.
  always_comb begin
    nonempty  = '0;
    head_addr = '0;
    head_data = '0;
    grant     = '0;
    for (int i = 0; i < LANES; i++) begin
      nonempty[i]  = (count[i] != '0);
      head_addr[i] = mem_addr[i][rd_ptr[i]];
      head_data[i] = mem_data[i][rd_ptr[i]];
    end
    for (int i = 0; i < LANES; i++) begin
      grant[i] = nonempty[i];
      for (int j = 0; j < LANES; j++) begin
        if ((j < i) && nonempty[j] && (head_addr[j] == head_addr[i])) begin
          grant[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < LANES; i++) begin
      if (push[i]) begin
        mem_addr[i][wr_ptr[i]] <= req_addr_i[i];
        mem_data[i][wr_ptr[i]] <= req_data_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        unique case ({push[i], grant[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Output stage: address/data hold when the lane is not granted.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      select_r_o       <= '0;
      data_o           <= '0;
      enable_writing_o <= '0;
    end else begin
      enable_writing_o <= grant;
      for (int i = 0; i < LANES; i++) begin
        if (grant[i]) begin
          select_r_o[i] <= head_addr[i];
          data_o[i]     <= head_data[i];
        end
      end
    end
  end

  assign busy_o = (|nonempty) || (|enable_writing_o);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a small behavioural register file sink.
module tb_rf_write_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NL = 4;

  logic                   clk;
  logic                   arst;
  logic [NL-1:0]          req_valid;
  logic [NL-1:0][AW-1:0]  req_addr;
  logic [NL-1:0][DW-1:0]  req_data;
  logic [NL-1:0]          req_ready;
  logic [NL-1:0][AW-1:0]  select_r;
  logic [NL-1:0][DW-1:0]  data_q;
  logic [NL-1:0]          enable_w;
  logic                   busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] rf [32] = '{default: '0};

  rf_write_arbiter #(
    .ADDRESS_WIDTH(AW), .WORD_WIDTH(DW), .LANES(NL), .DEPTH(2)
  ) dut (
    .clk_i           (clk),
    .arst_i          (arst),
    .req_valid_i     (req_valid),
    .req_addr_i      (req_addr),
    .req_data_i      (req_data),
    .req_ready_o     (req_ready),
    .select_r_o      (select_r),
    .data_o          (data_q),
    .enable_writing_o(enable_w),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file sink: commits whatever the arbiter presents.
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (enable_w[i]) rf[select_r[i]] <= data_q[i];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[l] = v;
    req_addr[l]  = a;
    req_data[l]  = d;
  endtask

  initial begin
    arst      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    tick();
    tick();
    check_eq("rst_ready", 64'(req_ready), 64'h0);
    check_eq("rst_en", 64'(enable_w), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_sel", 64'(select_r), 64'h0);
    check_eq("rst_data0", 64'(data_q[0]), 64'h0);
    arst = 1'b1;
    #1;
    check_eq("post_rst_ready", 64'(req_ready), 64'hF);

    // 1: four lanes, distinct addresses
    for (int i = 0; i < NL; i++) set_lane(i, 1'b1, AW'(i), DW'(i));
    tick();
    req_valid = '0;
    check_eq("t1_en_e0", 64'(enable_w), 64'h0);
    check_eq("t1_busy_e0", 64'(busy), 64'h1);
    tick();
    check_eq("t1_en_e1", 64'(enable_w), 64'hF);
    for (int i = 0; i < NL; i++) check_eq("t1_sel", 64'(select_r[i]), 64'(i));
    tick();
    check_eq("t1_en_e2", 64'(enable_w), 64'h0);
    check_eq("t1_busy_e2", 64'(busy), 64'h0);
    for (int i = 0; i < NL; i++) check_eq("t1_rf", 64'(rf[i]), 64'(i));

    // 2: lanes 0 and 2 collide on address 5
    set_lane(0, 1'b1, 5'd5, 32'd10);
    set_lane(2, 1'b1, 5'd5, 32'd20);
    tick();
    req_valid = '0;
    tick();
    check_eq("t2_en_a", 64'(enable_w), 64'h1);
    check_eq("t2_data0", 64'(data_q[0]), 64'd10);
    tick();
    check_eq("t2_en_b", 64'(enable_w), 64'h4);
    check_eq("t2_data2", 64'(data_q[2]), 64'd20);
    check_eq("t2_sel2", 64'(select_r[2]), 64'd5);
    tick();
    check_eq("t2_en_c", 64'(enable_w), 64'h0);
    check_eq("t2_rf5", 64'(rf[5]), 64'd20);

    // 3: back-to-back stream on lane 1
    for (int k = 1; k <= 3; k++) begin
      set_lane(1, 1'b1, 5'd7, DW'(k));
      check_eq("t3_ready", 64'(req_ready[1]), 64'h1);
      tick();
      if (k > 1) begin
        check_eq("t3_en", 64'(enable_w), 64'h2);
        check_eq("t3_data", 64'(data_q[1]), 64'(k - 1));
      end
    end
    req_valid = '0;
    tick();
    check_eq("t3_en_last", 64'(enable_w), 64'h2);
    check_eq("t3_data_last", 64'(data_q[1]), 64'd3);
    tick();
    check_eq("t3_en_idle", 64'(enable_w), 64'h0);

    // 4: lane 3 starved by a lane 0 stream to address 9
    set_lane(0, 1'b1, 5'd9, 32'd100);
    set_lane(3, 1'b1, 5'd9, 32'd200);
    tick();
    req_data[0] = 32'd101;
    req_data[3] = 32'd201;
    check_eq("t4_ready3_a", 64'(req_ready[3]), 64'h1);
    tick();
    check_eq("t4_ready3_full", 64'(req_ready[3]), 64'h0);
    check_eq("t4_en_e1", 64'(enable_w), 64'h1);
    check_eq("t4_d0_e1", 64'(data_q[0]), 64'd100);
    req_data[0] = 32'd102;
    req_data[3] = 32'd202;
    tick();
    check_eq("t4_ready3_b", 64'(req_ready[3]), 64'h0);
    check_eq("t4_d0_e2", 64'(data_q[0]), 64'd101);
    req_valid[0] = 1'b0;
    tick();
    check_eq("t4_en_e3", 64'(enable_w), 64'h1);
    check_eq("t4_d0_e3", 64'(data_q[0]), 64'd102);
    check_eq("t4_ready3_c", 64'(req_ready[3]), 64'h0);
    tick();
    check_eq("t4_en_e4", 64'(enable_w), 64'h8);
    check_eq("t4_d3_e4", 64'(data_q[3]), 64'd200);
    check_eq("t4_ready3_back", 64'(req_ready[3]), 64'h1);
    tick();
    req_valid[3] = 1'b0;
    check_eq("t4_d3_e5", 64'(data_q[3]), 64'd201);
    tick();
    check_eq("t4_d3_e6", 64'(data_q[3]), 64'd202);
    check_eq("t4_en_e6", 64'(enable_w), 64'h8);
    tick();
    check_eq("t4_en_e7", 64'(enable_w), 64'h0);
    check_eq("t4_rf9", 64'(rf[9]), 64'd202);

    // 6: idle, outputs hold
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("t6_en", 64'(enable_w), 64'h0);
      check_eq("t6_busy", 64'(busy), 64'h0);
    end
    check_eq("t6_sel3", 64'(select_r[3]), 64'd9);
    check_eq("t6_d3", 64'(data_q[3]), 64'd202);
    check_eq("t6_d1", 64'(data_q[1]), 64'd3);
    check_eq("t6_sel2", 64'(select_r[2]), 64'd5);

    // 5: reset with a write in flight and two entries queued
    set_lane(1, 1'b1, 5'd12, 32'h55);
    tick();
    req_valid = '0;
    set_lane(0, 1'b1, 5'd20, 32'h66);
    set_lane(2, 1'b1, 5'd20, 32'h77);
    tick();
    check_eq("t5_en_pre", 64'(enable_w), 64'h2);
    check_eq("t5_busy_pre", 64'(busy), 64'h1);
    set_lane(0, 1'b1, 5'd21, 32'hAB);
    req_valid[2] = 1'b0;
    arst = 1'b0;
    #1;
    check_eq("t5_en_rst", 64'(enable_w), 64'h0);
    check_eq("t5_busy_rst", 64'(busy), 64'h0);
    check_eq("t5_ready_rst", 64'(req_ready), 64'h0);
    tick();
    tick();
    arst = 1'b1;
    req_valid = '0;
    #1;
    check_eq("t5_ready_rel", 64'(req_ready), 64'hF);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("t5_en_after", 64'(enable_w), 64'h0);
      check_eq("t5_busy_after", 64'(busy), 64'h0);
    end
    check_eq("t5_rf12", 64'(rf[12]), 64'h0);
    check_eq("t5_rf20", 64'(rf[20]), 64'h0);
    check_eq("t5_rf21", 64'(rf[21]), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Write-side front end for the multi-port register file (RF_32x write ports).
- Collects register writeback results from up to LANES execution lanes through per-lane valid/ready FIFOs.
- Resolves same-destination collisions between lanes.
- Drives the RF select_r / data / enable_writing ports from registered outputs, so the RF never sees two writes to one address in one cycle.

Parameters:
ADDRESS_WIDTH, 5, register address width (matches RF).
WORD_WIDTH, 32, data word width (matches RF).
LANES, 4, number of writeback lanes = number of RF write ports.
DEPTH, 2, per-lane FIFO depth; power of two, >= 2.

Ports:
clk_i  input  1  clock, all state on rising edge.
arst_i  input  1  asynchronous reset, active-low.
req_valid_i  input  [LANES]  lane has a write request.
req_addr_i  input  [LANES][ADDRESS_WIDTH]  destination register per lane.
req_data_i  input  [LANES][WORD_WIDTH]  write data per lane.
req_ready_o  output  [LANES]  lane FIFO can accept this cycle.
select_r_o  output  [LANES][ADDRESS_WIDTH]  to RF select_r_i.
data_o  output  [LANES][WORD_WIDTH]  to RF data_i.
enable_writing_o  output  [LANES]  to RF enable_writing_i.
busy_o  output  1  any FIFO non-empty or any enable_writing_o bit set.

Behaviour:
- Reset (arst_i low, asynchronous):
  - All FIFO pointers and counts clear to 0.
  - select_r_o = 0, data_o = 0, enable_writing_o = 0, busy_o = 0.
  - req_ready_o forced to 0 combinationally while arst_i is low; no request is accepted during reset.
- Reset asserted mid-operation: all queued and in-flight writes are discarded, and output enables drop immediately.
- Accept:
  - Lane i pushes when req_valid_i[i] & req_ready_o[i].
  - req_ready_o[i] = (count_i != DEPTH); it depends only on registered count.
  - There is no full-FIFO bypass: a full FIFO is not ready even if it pops that cycle.
  - Data is held stable by the sender until accepted; the arbiter does not sample unaccepted data.
- Grant (combinational on FIFO heads each cycle):
  - Candidate lanes are those whose FIFO is non-empty.
  - If two or more candidate heads share an address, the lowest lane index wins; the higher lanes stall and keep their head.
  - All non-conflicting candidates are granted in the same cycle.
  - Granted heads are popped at the clock edge.
- Output stage (registered, one register per lane):
  - On each edge, enable_writing_o[i] <= grant[i].
  - If grant[i], select_r_o[i] and data_o[i] load the head address and data.
  - If not granted, select_r_o[i] and data_o[i] hold their previous value, and enable_writing_o[i] = 0.
- Latency:
  - A request accepted at edge E0 into an empty, uncontested lane is popped and presented at edge E1 (enable high for cycle E1..E2).
  - The RF commits it at E2.
  - Throughput is 1 write per lane per cycle.
- Simultaneous push and pop on the same lane in one cycle: count unchanged, pointers both advance.
- Ordering:
  - Order within a lane is strict FIFO.
  - Order across lanes to the same address follows lane priority, not arrival order; the producer must not rely on cross-lane write order.
- Invariant: no two set bits of enable_writing_o ever carry equal select_r_o values.
- Pointer width is log2(DEPTH); pointers wrap naturally at DEPTH.
- Count width is log2(DEPTH)+1.
- Output lane i always maps to input lane i; there is no lane remapping.
- busy_o is combinational from counts and enable_writing_o.

Test Plan:
1. Reset, then push lanes 0..3 with addr 0..3 and data 0..3 in one cycle -> next cycle enable_writing_o=4'b1111, select_r_o={3,2,1,0}; the RF then reads back A[0..3]=0,1,2,3.
2. Push lane0 (addr 5, data 10) and lane2 (addr 5, data 20) together -> first output cycle enable=4'b0001 with data_o[0]=10; next cycle enable=4'b0100 with data_o[2]=20; RF reg5 ends at 20.
3. Push lane1 three times back-to-back (addr 7, data 1, 2, 3):
   - Ready stays 1 on all three pushes, since one entry pops each cycle.
   - Output lane1 shows data 1, 2, 3 on consecutive cycles.
4. Hold lane3's head blocked by a stream of lane0 writes to the same address:
   - Lane3 FIFO fills, and req_ready_o[3]=0 after two accepted entries.
   - When lane0 stops, lane3 drains in order and ready returns to 1.
5. Assert arst_i low with two entries queued and enable_writing_o=4'b0010 -> enable, busy_o and req_ready_o go to 0 immediately with no clock edge; after release, no stale write ever appears.
6. Idle with no valid requests -> enable_writing_o=0 and busy_o=0 indefinitely; select_r_o/data_o hold their last values.
